// File: rtl/att_core_sequencer.sv
// Buffers N token/bias pairs, replays them to the attention core as one enabled frame,
// then collects the core's results and drains them downstream with a last marker.
module att_core_sequencer #(
  parameter int unsigned DW      = 16,
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  input  logic [DW-1:0] s_data_i,
  input  logic [DW-1:0] s_bias_i,
  output logic          core_en_o,
  output logic [DW-1:0] core_att_o,
  output logic [DW-1:0] core_bias_o,
  input  logic          core_end_i,
  input  logic [DW-1:0] core_o_att_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_data_o,
  output logic          m_last_o,
  output logic          busy_o,
  output logic          err_timeout_o
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned TW = $clog2(TIMEOUT);

  localparam logic [CW-1:0] NCnt    = CW'(N);
  localparam logic [CW-1:0] NLast   = CW'(N - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TmoOne  = TW'(1);

  typedef enum logic [1:0] {StLoad, StStream, StWait, StDrain} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]       str_cnt_q, str_cnt_d;
  logic [CW-1:0]       res_cnt_q, res_cnt_d;
  logic [CW-1:0]       rd_cnt_q, rd_cnt_d;
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [2*DW-1:0]     ibuf_q [N];
  logic [2*DW-1:0]     ibuf_d [N];
  logic [DW-1:0]       obuf_q [N];
  logic [DW-1:0]       obuf_d [N];
  logic                err_q, err_d;

  logic                s_ready_q, s_ready_d;
  logic                core_en_q, core_en_d;
  logic [DW-1:0]       core_att_q, core_att_d;
  logic [DW-1:0]       core_bias_q, core_bias_d;
  logic                m_valid_q, m_valid_d;
  logic [DW-1:0]       m_data_q, m_data_d;
  logic                m_last_q, m_last_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    str_cnt_d = str_cnt_q;
    res_cnt_d = res_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    ibuf_d    = ibuf_q;
    obuf_d    = obuf_q;
    err_d     = err_q;

    case (state_q)
      StLoad: begin
        if (s_valid_i && s_ready_q) begin
          ibuf_d[wr_cnt_q[IW-1:0]] = {s_data_i, s_bias_i};
          if (wr_cnt_q == '0) err_d = 1'b0;
          if (wr_cnt_q == NLast) begin
            state_d   = StStream;
            wr_cnt_d  = '0;
            str_cnt_d = '0;
            res_cnt_d = '0;
            rd_cnt_d  = '0;
            tmo_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + CntOne;
          end
        end
      end
      StStream: begin
        // The core may finish early, so results are captured while streaming too.
        if (core_end_i && (res_cnt_q != NCnt)) begin
          obuf_d[res_cnt_q[IW-1:0]] = core_o_att_i;
          res_cnt_d = res_cnt_q + CntOne;
        end
        if (str_cnt_q == NLast) begin
          state_d   = (res_cnt_d == NCnt) ? StDrain : StWait;
          str_cnt_d = '0;
          tmo_cnt_d = '0;
        end else begin
          str_cnt_d = str_cnt_q + CntOne;
        end
      end
      StWait: begin
        if (core_end_i) begin
          obuf_d[res_cnt_q[IW-1:0]] = core_o_att_i;
          res_cnt_d = res_cnt_q + CntOne;
          tmo_cnt_d = '0;
          if (res_cnt_q == NLast) state_d = StDrain;
        end else if (tmo_cnt_q == TmoLast) begin
          err_d     = 1'b1;
          tmo_cnt_d = '0;
          if (res_cnt_q != '0) begin
            state_d = StDrain;
          end else begin
            state_d   = StLoad;
            res_cnt_d = '0;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoOne;
        end
      end
      StDrain: begin
        if (m_valid_q && m_ready_i) begin
          if (rd_cnt_q == res_cnt_q - CntOne) begin
            state_d   = StLoad;
            wr_cnt_d  = '0;
            str_cnt_d = '0;
            res_cnt_d = '0;
            rd_cnt_d  = '0;
            tmo_cnt_d = '0;
          end else begin
            rd_cnt_d = rd_cnt_q + CntOne;
          end
        end
      end
      default: state_d = StLoad;
    endcase

    // Outputs are registered from next-state values so they line up with the state they describe.
    s_ready_d   = (state_d == StLoad);
    core_en_d   = (state_d == StStream) || (state_d == StWait);
    core_att_d  = '0;
    core_bias_d = '0;
    if (state_d == StStream) {core_att_d, core_bias_d} = ibuf_d[str_cnt_d[IW-1:0]];
    m_valid_d = (state_d == StDrain);
    m_data_d  = '0;
    m_last_d  = 1'b0;
    if (state_d == StDrain) begin
      m_data_d = obuf_d[rd_cnt_d[IW-1:0]];
      m_last_d = (rd_cnt_d == res_cnt_d - CntOne);
    end
    busy_d = (state_d != StLoad);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StLoad;
      wr_cnt_q    <= '0;
      str_cnt_q   <= '0;
      res_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
      s_ready_q   <= 1'b1;
      core_en_q   <= 1'b0;
      core_att_q  <= '0;
      core_bias_q <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        ibuf_q[i] <= '0;
        obuf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      str_cnt_q   <= str_cnt_d;
      res_cnt_q   <= res_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      err_q       <= err_d;
      s_ready_q   <= s_ready_d;
      core_en_q   <= core_en_d;
      core_att_q  <= core_att_d;
      core_bias_q <= core_bias_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      busy_q      <= busy_d;
      ibuf_q      <= ibuf_d;
      obuf_q      <= obuf_d;
    end
  end

  assign s_ready_o     = s_ready_q;
  assign core_en_o     = core_en_q;
  assign core_att_o    = core_att_q;
  assign core_bias_o   = core_bias_q;
  assign m_valid_o     = m_valid_q;
  assign m_data_o      = m_data_q;
  assign m_last_o      = m_last_q;
  assign busy_o        = busy_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_att_core_sequencer.sv
// Job-table bench for att_core_sequencer: drives upstream pairs and a scripted core,
// scoreboards the drained results.
module tb_att_core_sequencer;

  localparam int unsigned DW      = 16;
  localparam int unsigned N       = 4;
  localparam int unsigned TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic [DW-1:0] s_bias = '0;
  logic          core_en;
  logic [DW-1:0] core_att;
  logic [DW-1:0] core_bias;
  logic          core_end = 1'b0;
  logic [DW-1:0] core_o_att = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          err_timeout;

  always #5 clk = ~clk;

  att_core_sequencer #(.DW(DW), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_valid_i     (s_valid),
    .s_ready_o     (s_ready),
    .s_data_i      (s_data),
    .s_bias_i      (s_bias),
    .core_en_o     (core_en),
    .core_att_o    (core_att),
    .core_bias_o   (core_bias),
    .core_end_i    (core_end),
    .core_o_att_i  (core_o_att),
    .m_valid_o     (m_valid),
    .m_ready_i     (m_ready),
    .m_data_o      (m_data),
    .m_last_o      (m_last),
    .busy_o        (busy),
    .err_timeout_o (err_timeout)
  );

  // Per-lane arrays: element i is lane i (rightmost in a concatenation is lane 0).
  typedef struct packed {
    logic [3:0][15:0] tok;
    logic [3:0][15:0] bias;
    logic [3:0][15:0] res;
    int               nres;
    int               gap;
    int               lat;
    int               early;
    int               stall_at;
    int               stall_len;
    logic             junk;
  } job_t;

  job_t          jobs [5];
  logic [DW:0]   sb_q [$];
  int            total = 0;
  int            bad = 0;
  logic          exp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: at the falling edge, score any downstream handshake; return 1 time unit
  // after the next rising edge, when outputs are settled and inputs may change.
  task automatic tick();
    logic [DW:0] exp_w;
    @(negedge clk);
    if (m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL m_extra: got word %0h, want no output", m_data);
      end else begin
        exp_w = sb_q.pop_front();
        chk("m_data", 32'(m_data), 32'(exp_w[DW-1:0]));
        chk("m_last", 32'(m_last), 32'(exp_w[DW]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int j);
    job_t jb;
    int   ridx;
    jb   = jobs[j];
    ridx = 0;
    chk("err_before_job", 32'(err_timeout), 32'(exp_err));
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1;
      s_data  = jb.tok[i];
      s_bias  = jb.bias[i];
      chk("s_ready_load", 32'(s_ready), 32'd1);
      tick();
      if (i == 0) chk("err_clear_first", 32'(err_timeout), 32'd0);
      if (i < N - 1) begin
        chk("busy_load", 32'(busy), 32'd0);
        if (jb.gap != 0) begin
          s_valid = 1'b0;
          tick();
          chk("s_ready_gap", 32'(s_ready), 32'd1);
        end
      end
    end
    // Upstream traffic outside LOAD must be ignored.
    s_valid = jb.junk;
    s_data  = 16'hdead;
    s_bias  = 16'hbeef;
    for (int k = 0; k < N; k++) begin
      chk("stream_en", 32'(core_en), 32'd1);
      chk("stream_att", 32'(core_att), 32'(jb.tok[k]));
      chk("stream_bias", 32'(core_bias), 32'(jb.bias[k]));
      chk("stream_s_ready", 32'(s_ready), 32'd0);
      if ((k >= N - jb.early) && (ridx < jb.nres)) begin
        core_end   = 1'b1;
        core_o_att = jb.res[ridx];
        sb_q.push_back({ridx == jb.nres - 1, jb.res[ridx]});
        ridx++;
      end else begin
        core_end = 1'b0;
      end
      tick();
    end
    core_end = 1'b0;
    chk("wait_en", 32'(core_en), 32'd1);
    chk("wait_att", 32'(core_att), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    while (ridx < jb.nres) begin
      repeat (jb.lat) tick();
      core_end   = 1'b1;
      core_o_att = jb.res[ridx];
      sb_q.push_back({ridx == jb.nres - 1, jb.res[ridx]});
      ridx++;
      tick();
      core_end = 1'b0;
    end
    s_valid = 1'b0;
    if (jb.nres < N) begin
      repeat (TIMEOUT - 1) tick();
      chk("tmo_still_wait", 32'(core_en), 32'd1);
      chk("tmo_err_early", 32'(err_timeout), 32'd0);
      tick();
      chk("tmo_err", 32'(err_timeout), 32'd1);
      chk("tmo_core_en", 32'(core_en), 32'd0);
      chk("tmo_m_valid", 32'(m_valid), 32'(jb.nres > 0));
      chk("tmo_s_ready", 32'(s_ready), 32'(jb.nres == 0));
    end else begin
      chk("drain_entry_valid", 32'(m_valid), 32'd1);
      chk("drain_core_en", 32'(core_en), 32'd0);
    end
    for (int r = 0; r < jb.nres; r++) begin
      if (r == jb.stall_at) begin
        m_ready = 1'b0;
        for (int c = 0; c < jb.stall_len; c++) begin
          tick();
          chk("stall_valid", 32'(m_valid), 32'd1);
          chk("stall_data", 32'(m_data), 32'(jb.res[r]));
          chk("stall_last", 32'(m_last), 32'(r == jb.nres - 1));
        end
      end
      m_ready = 1'b1;
      tick();
    end
    chk("end_s_ready", 32'(s_ready), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_m_valid", 32'(m_valid), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    exp_err = (jb.nres < N);
  endtask

  initial begin
    jobs[0] = '0;
    jobs[0].tok       = {16'd4, 16'd3, 16'd2, 16'd1};
    jobs[0].res       = {16'd40, 16'd30, 16'd20, 16'd10};
    jobs[0].nres      = 4;
    jobs[0].lat       = 1;
    jobs[0].stall_at  = -1;

    jobs[1] = '0;
    jobs[1].tok       = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
    jobs[1].bias      = {16'd103, 16'd102, 16'd101, 16'd100};
    jobs[1].res       = {16'd40, 16'd30, 16'd20, 16'd10};
    jobs[1].nres      = 4;
    jobs[1].gap       = 1;
    jobs[1].stall_at  = 1;
    jobs[1].stall_len = 5;

    jobs[2] = '0;
    jobs[2].tok       = {16'h1234, 16'h00ff, 16'h8000, 16'hffff};
    jobs[2].bias      = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
    jobs[2].res       = {16'h0, 16'h0, 16'h5555, 16'haaaa};
    jobs[2].nres      = 2;
    jobs[2].lat       = 2;
    jobs[2].stall_at  = -1;

    jobs[3] = '0;
    jobs[3].tok       = {16'h0d0d, 16'h0c0c, 16'h0b0b, 16'h0a0a};
    jobs[3].bias      = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    jobs[3].stall_at  = -1;

    jobs[4] = '0;
    jobs[4].tok       = {16'h0f0f, 16'hf0f0, 16'h0001, 16'hfffe};
    jobs[4].bias      = {16'h7fff, 16'h0000, 16'hc3c3, 16'h3c3c};
    jobs[4].res       = {16'hbeef, 16'hcafe, 16'h0042, 16'h9999};
    jobs[4].nres      = 4;
    jobs[4].lat       = 3;
    jobs[4].early     = 2;
    jobs[4].stall_at  = 3;
    jobs[4].stall_len = 2;
    jobs[4].junk      = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_core_att", 32'(core_att), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    rstn = 1'b1;
    tick();

    for (int j = 0; j < 5; j++) run_job(j);

    // Reset while waiting on the core, with one result already captured.
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h00a0 + 16'(i);
      s_bias  = 16'h0;
      tick();
    end
    s_valid = 1'b0;
    repeat (N) tick();
    core_end   = 1'b1;
    core_o_att = 16'h0077;
    tick();
    core_end = 1'b0;
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_core_en", 32'(core_en), 32'd0);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_err", 32'(err_timeout), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_err = 1'b0;
    tick();
    run_job(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
